// File: rtl/sram_2port_write_sequencer.sv
// Write-port sequencer for the 2-port adiabatic SRAM bank.
// Arbitrates two requesters round-robin and paces each write against the
// Bennett phase vector: address/data launch on the DATA_PHASE rising edge, and
// the write strobe spans the WRITE_PHASE high window. At most one write per
// Bennett cycle.
module sram_2port_write_sequencer #(
  parameter int unsigned PHASES      = 10,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_PHASE  = 3,
  parameter int unsigned WRITE_PHASE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PHASES-1:0] clkp,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              data1,
  output logic              ack0,
  output logic              ack1,
  output logic              wr_in,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              write,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StDone} state_e;

  state_e              state_q, state_d;
  logic [PHASES-1:0]   ph_q;
  logic                rr_ptr_q, rr_ptr_d;
  logic                grant_q, grant_d;
  logic                ack0_d, ack1_d;
  logic                wr_in_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic                write_d;
  logic                busy_d;
  logic                winner;
  logic                rise_data;
  logic                rise_write;
  logic                fall_write;

  // Phase edges are seen on the same clk edge that first samples the new level.
  assign rise_data  =  clkp[DATA_PHASE]  & ~ph_q[DATA_PHASE];
  assign rise_write =  clkp[WRITE_PHASE] & ~ph_q[WRITE_PHASE];
  assign fall_write = ~clkp[WRITE_PHASE] &  ph_q[WRITE_PHASE];

  // Arbitration: sole requester wins; on contention the round-robin pointer decides.
  always_comb begin
    winner = rr_ptr_q;
    if (!(req0 && req1)) begin
      winner = req1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    wr_in_d   = wr_in;
    wr_addr_d = wr_addr;
    write_d   = write;
    busy_d    = busy;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise_data && (req0 || req1)) begin
          grant_d   = winner;
          rr_ptr_d  = ~winner;
          wr_addr_d = winner ? addr1 : addr0;
          wr_in_d   = winner ? data1 : data0;
          busy_d    = 1'b1;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (rise_write) begin
          write_d = 1'b1;
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        if (fall_write) begin
          write_d = 1'b0;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register; reset aborts any write in flight without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ph_q     <= '0;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      wr_in    <= 1'b0;
      wr_addr  <= '0;
      write    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= clkp;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      wr_in    <= wr_in_d;
      wr_addr  <= wr_addr_d;
      write    <= write_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_2port_write_sequencer.sv
// Directed bench for sram_2port_write_sequencer. A 24-clk Bennett cycle is
// generated with nested phase windows: clkp[k] is high for cycle counts
// k+1 .. 22-k, so clkp[3] rises at count 4 and clkp[8] is high for 9..14.
module tb_sram_2port_write_sequencer;

  localparam int unsigned PHASES = 10;
  localparam int unsigned ADDR_W = 4;
  localparam int          PERIOD = 24;

  logic              clk;
  logic              reset;
  logic [PHASES-1:0] clkp;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              data0, data1;
  logic              ack0, ack1;
  logic              wr_in;
  logic [ADDR_W-1:0] wr_addr;
  logic              write;
  logic              busy;

  int cnt;
  bit hold;
  int n_checks;
  int n_pass;

  sram_2port_write_sequencer #(
    .PHASES      (PHASES),
    .ADDR_W      (ADDR_W),
    .DATA_PHASE  (3),
    .WRITE_PHASE (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clkp    (clkp),
    .req0    (req0),
    .addr0   (addr0),
    .data0   (data0),
    .req1    (req1),
    .addr1   (addr1),
    .data1   (data1),
    .ack0    (ack0),
    .ack1    (ack1),
    .wr_in   (wr_in),
    .wr_addr (wr_addr),
    .write   (write),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PHASES-1:0] phase_vec(input int t);
    logic [PHASES-1:0] v;
    for (int k = 0; k < PHASES; k++) v[k] = (t >= k + 1) && (t < 23 - k);
    return v;
  endfunction

  // Phase generator: advances on the falling clk edge unless frozen.
  initial begin
    cnt  = PERIOD - 1;
    clkp = '0;
    forever begin
      @(negedge clk);
      if (!hold) begin
        cnt  = (cnt + 1) % PERIOD;
        clkp = phase_vec(cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the edge that processed count 23.
  task automatic align();
    int g;
    g = 0;
    while (cnt != PERIOD - 1 && g < 100) begin
      tick();
      g++;
    end
    if (cnt != PERIOD - 1) check_eq("align", cnt, PERIOD - 1);
  endtask

  task automatic wait_cnt(input int c);
    int g;
    g = 0;
    while (cnt != c && g < 100) begin
      tick();
      g++;
    end
    if (cnt != c) check_eq("wait_cnt", cnt, c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    wait_cnt(21);
    reset = 1'b0;
  endtask

  // One full Bennett cycle with expected grant id, address and data.
  task automatic bennett_cycle(input bit gnt, input bit id, input logic [3:0] a, input bit d,
                               input bit chg, input bit drop);
    int n_wr, n_a0, n_a1;
    n_wr = 0;
    n_a0 = 0;
    n_a1 = 0;
    align();
    for (int t = 0; t < PERIOD; t++) begin
      tick();
      if (write) n_wr++;
      if (ack0) n_a0++;
      if (ack1) n_a1++;
      if (gnt) begin
        if (t == 3) check_eq("busy_pre_grant", busy, 0);
        if (t == 4) begin
          check_eq("busy_grant", busy, 1);
          check_eq("wr_addr_grant", wr_addr, a);
          check_eq("wr_in_grant", wr_in, d);
        end
        if (t == 6 && chg) data0 = ~data0;
        if (t == 8) check_eq("write_pre", write, 0);
        if (t == 9) check_eq("write_rise", write, 1);
        if (t == 12) check_eq("wr_in_hold", wr_in, d);
        if (t == 15) begin
          check_eq("ack_pulse", id ? ack1 : ack0, 1);
          check_eq("write_fall", write, 0);
          check_eq("busy_at_ack", busy, 1);
          if (drop) begin
            if (id) req1 = 1'b0;
            else    req0 = 1'b0;
          end
        end
        if (t == 16) begin
          check_eq("busy_done", busy, 0);
          check_eq("ack_clear", {ack1, ack0}, 0);
        end
        if (t == 23) check_eq("wr_addr_keep", wr_addr, a);
      end
    end
    check_eq("write_cycles", n_wr, gnt ? 6 : 0);
    check_eq("ack0_count", n_a0, (gnt && !id) ? 1 : 0);
    check_eq("ack1_count", n_a1, (gnt && id) ? 1 : 0);
  endtask

  initial begin
    int n_wr, n_ack;
    n_checks = 0;
    n_pass   = 0;
    hold  = 1'b0;
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    addr0 = '0;
    addr1 = '0;
    data0 = 1'b0;
    data1 = 1'b0;

    // Reset state.
    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_write", write, 0);
    check_eq("rst_ack", {ack1, ack0}, 0);
    check_eq("rst_wr_in", wr_in, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    wait_cnt(21);
    reset = 1'b0;

    // Idle cycle: nothing requested, nothing happens.
    bennett_cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Single write from requester 0.
    req0 = 1'b1; addr0 = 4'd5; data0 = 1'b1;
    bennett_cycle(1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1);

    // Contention from reset: 0 first, then 1.
    req0 = 1'b1; addr0 = 4'd2; data0 = 1'b0;
    req1 = 1'b1; addr1 = 4'd9; data1 = 1'b1;
    do_reset();
    bennett_cycle(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    bennett_cycle(1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b1);

    // Fairness: both held for four cycles.
    req0 = 1'b1; addr0 = 4'd4;  data0 = 1'b1;
    req1 = 1'b1; addr1 = 4'd11; data1 = 1'b0;
    bennett_cycle(1'b1, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0);
    bennett_cycle(1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
    bennett_cycle(1'b1, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0);
    bennett_cycle(1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;

    // Late request: raised after the grant edge, served next cycle.
    align();
    repeat (5) tick();
    check_eq("late_busy", busy, 0);
    req1 = 1'b1; addr1 = 4'd12; data1 = 1'b1;
    n_wr = 0;
    for (int t = 5; t < PERIOD; t++) begin
      tick();
      if (write) n_wr++;
    end
    check_eq("late_no_write", n_wr, 0);
    bennett_cycle(1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1);

    // Data change during SETUP does not reach the write.
    req0 = 1'b1; addr0 = 4'd7; data0 = 1'b1;
    bennett_cycle(1'b1, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1);

    // Reset mid-strobe: abort without ack, redo next cycle.
    req0 = 1'b1; addr0 = 4'd3; data0 = 1'b1;
    align();
    repeat (12) tick();
    check_eq("strobe_active", write, 1);
    reset = 1'b1;
    #1;
    check_eq("abort_write", write, 0);
    check_eq("abort_busy", busy, 0);
    n_ack = 0;
    while (cnt != 21 && n_ack < 1000) begin
      tick();
      if (ack0 || ack1) n_ack += 1;
      else n_ack += 0;
      if (cnt == 15 || cnt == 16) check_eq("abort_no_ack", {ack1, ack0}, 0);
    end
    reset = 1'b0;
    bennett_cycle(1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1);

    // Frozen clkp at 0: no edges, no grant, outputs hold.
    req0 = 1'b1; addr0 = 4'd1; data0 = 1'b0;
    align();
    hold = 1'b1;
    n_wr = 0;
    repeat (40) begin
      tick();
      if (busy || write) n_wr++;
    end
    check_eq("hold_idle", n_wr, 0);
    check_eq("hold_wr_addr", wr_addr, 3);
    check_eq("hold_wr_in", wr_in, 1);
    hold = 1'b0;
    bennett_cycle(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
